// File: rtl/edge_pkg.sv
// +----------------------------------------------------------------------+
// | edge_pkg: shared types and constants for the edge post-processor.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package edge_pkg;

  localparam logic [11:0] PIX_MAX   = 12'hFFF;
  localparam logic [10:0] MAG_SAT   = 11'd2047;
  localparam int          IMG_W_DEF = 640;
  localparam int          IMG_H_DEF = 480;

  typedef enum logic {S_IDLE, S_ACTIVE} pp_state_t;

  typedef struct packed {
    logic [10:0] mag;
    logic        hit;
    logic        mode;
    logic [10:0] x;
    logic [10:0] y;
    logic        last;
    logic        valid;
  } s1_payload_t;

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// +----------------------------------------------------------------------+
// | raster_counter: x/y raster position with advance enable and wrap.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module raster_counter
  import edge_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        adv_i,
  output logic [10:0] x_o,
  output logic [10:0] y_o,
  output logic        x_wrap_o,
  output logic        last_o
);

  localparam logic [10:0] X_MAX = 11'(IMG_W - 1);
  localparam logic [10:0] Y_MAX = 11'(IMG_H - 1);

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;

  assign x_wrap_o = (x_q == X_MAX);
  assign last_o   = x_wrap_o && (y_q == Y_MAX);
  assign x_o      = x_q;
  assign y_o      = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (adv_i) begin
      if (x_wrap_o) begin
        x_d = '0;
        y_d = last_o ? '0 : y_q + 11'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/edge_postproc.sv
// +----------------------------------------------------------------------+
// | edge_postproc: Sobel result -> grey RGB pixel, raster coordinates    |
// | and per-frame edge count. Rev 1.0                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module edge_postproc
  import edge_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DATA_W = 12,
  parameter int CNT_W  = 19
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iMODE,
  input  logic [DATA_W-1:0] iTHRESH,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              oDVAL,
  output logic [10:0]       oX_Cont,
  output logic [10:0]       oY_Cont,
  output logic [CNT_W-1:0]  oEdge_Count,
  output logic              oFrame_Done
);

  logic [DATA_W-1:0] abs_w;
  logic [10:0]       mag_w;
  logic              hit_w;
  logic [10:0]       x_w, y_w;
  logic              last_w;
  logic              unused_xwrap_w;

  // Only -2048 sets the top bit of the absolute value; it saturates.
  assign abs_w = iDATA[DATA_W-1] ? (DATA_W'(0) - iDATA) : iDATA;
  assign mag_w = abs_w[DATA_W-1] ? MAG_SAT : abs_w[DATA_W-2:0];
  assign hit_w = ({1'b0, mag_w} >= iTHRESH);

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_raster (
    .clk_i    (iCLK),
    .rst_i    (iRST),
    .adv_i    (iDVAL),
    .x_o      (x_w),
    .y_o      (y_w),
    .x_wrap_o (unused_xwrap_w),
    .last_o   (last_w)
  );

  s1_payload_t s1_q, s1_d;

  always_comb begin
    s1_d       = '0;
    s1_d.mag   = mag_w;
    s1_d.hit   = hit_w;
    s1_d.mode  = iMODE;
    s1_d.x     = x_w;
    s1_d.y     = y_w;
    s1_d.last  = last_w;
    s1_d.valid = iDVAL;
  end

  logic [DATA_W-1:0] pix_w;
  logic [CNT_W-1:0]  run_q, run_inc_w;
  logic [DATA_W-1:0] pix_q;
  logic              dval_q, done_q;
  logic [10:0]       x_q, y_q;
  logic [CNT_W-1:0]  cnt_q;

  assign pix_w     = s1_q.mode ? (s1_q.hit ? PIX_MAX : '0) : {s1_q.mag, 1'b0};
  assign run_inc_w = run_q + {{(CNT_W-1){1'b0}}, s1_q.hit};

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_q   <= '0;
      pix_q  <= '0;
      dval_q <= 1'b0;
      done_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      run_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      dval_q <= s1_q.valid;
      done_q <= s1_q.valid & s1_q.last;
      if (s1_q.valid) begin
        pix_q <= pix_w;
        x_q   <= s1_q.x;
        y_q   <= s1_q.y;
        // Frame total includes the last pixel's own hit.
        if (s1_q.last) begin
          cnt_q <= run_inc_w;
          run_q <= '0;
        end else begin
          run_q <= run_inc_w;
        end
      end
    end
  end

  assign oRed        = pix_q;
  assign oGreen      = pix_q;
  assign oBlue       = pix_q;
  assign oDVAL       = dval_q;
  assign oX_Cont     = x_q;
  assign oY_Cont     = y_q;
  assign oEdge_Count = cnt_q;
  assign oFrame_Done = done_q;

  pp_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (iDVAL) state_d = S_ACTIVE;
      S_ACTIVE: if (iDVAL && last_w) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

endmodule

`default_nettype wire
